// File: rtl/peripheral_mailbox.sv
// Peripheral-side mailbox: terminates the core's command stream, buffers
// core-to-host words (TX) and host-to-core words (RX), and serves blocking
// reads on an empty RX FIFO with a bounded wait.
module peripheral_mailbox #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            to_peripheral,
    input  logic [DATA_WIDTH-1:0] to_peripheral_data,
    input  logic                  to_peripheral_valid,
    output logic [1:0]            from_peripheral,
    output logic [DATA_WIDTH-1:0] from_peripheral_data,
    output logic                  from_peripheral_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] CmdNop = 2'b00;
    localparam logic [1:0] CmdWrite = 2'b01;
    localparam logic [1:0] CmdRead = 2'b10;
    localparam logic [1:0] CmdStatus = 2'b11;

    localparam logic [1:0] RespNone = 2'b00;
    localparam logic [1:0] RespAck = 2'b01;
    localparam logic [1:0] RespData = 2'b10;
    localparam logic [1:0] RespErr = 2'b11;

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e                state_q;
    logic [TmoW-1:0]       wait_cnt_q;
    logic                  dropped_q;

    logic [DATA_WIDTH-1:0] tx_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] rx_mem [FIFO_DEPTH];
    logic [PtrW-1:0]       tx_wptr_q, tx_rptr_q, rx_wptr_q, rx_rptr_q;
    logic [CntW-1:0]       tx_count_q, rx_count_q;

    logic                  tx_full, tx_empty, rx_full, rx_empty;
    logic                  accept, tx_push, tx_pop, rx_push, rx_pop;
    logic [DATA_WIDTH-1:0] rx_head, status_word;

    assign tx_full  = (tx_count_q == CntW'(FIFO_DEPTH));
    assign tx_empty = (tx_count_q == '0);
    assign rx_full  = (rx_count_q == CntW'(FIFO_DEPTH));
    assign rx_empty = (rx_count_q == '0);

    // Full/empty are pre-edge, so a pop never frees a slot for a same-cycle push.
    assign accept  = to_peripheral_valid && (state_q == StIdle);
    assign tx_push = accept && (to_peripheral == CmdWrite) && !tx_full;
    assign tx_pop  = !tx_empty && tx_ready;
    assign rx_push = rx_valid && !rx_full;
    assign rx_pop  = !rx_empty && ((accept && (to_peripheral == CmdRead)) || (state_q == StWait));

    assign rx_head  = rx_mem[rx_rptr_q];
    assign tx_data  = tx_empty ? '0 : tx_mem[tx_rptr_q];
    assign tx_valid = !tx_empty;
    assign rx_ready = !rx_full;

    // Status word: flags in [4:0], tx_count in [15:8], rx_count in [23:16].
    always_comb begin
        status_word          = '0;
        status_word[0]       = tx_full;
        status_word[1]       = tx_empty;
        status_word[2]       = rx_full;
        status_word[3]       = rx_empty;
        status_word[4]       = dropped_q;
        status_word[8+:CntW] = tx_count_q;
        status_word[16+:CntW] = rx_count_q;
    end

    // FIFO storage; contents need no reset since counts gate every read.
    always_ff @(posedge clock) begin
        if (tx_push) tx_mem[tx_wptr_q] <= to_peripheral_data;
        if (rx_push) rx_mem[rx_wptr_q] <= rx_data;
    end

    // FIFO pointers and occupancy counts.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            tx_count_q <= '0;
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            rx_count_q <= '0;
        end else begin
            if (tx_push) tx_wptr_q <= tx_wptr_q + PtrW'(1);
            if (tx_pop) tx_rptr_q <= tx_rptr_q + PtrW'(1);
            if (tx_push && !tx_pop) tx_count_q <= tx_count_q + CntW'(1);
            else if (!tx_push && tx_pop) tx_count_q <= tx_count_q - CntW'(1);
            if (rx_push) rx_wptr_q <= rx_wptr_q + PtrW'(1);
            if (rx_pop) rx_rptr_q <= rx_rptr_q + PtrW'(1);
            if (rx_push && !rx_pop) rx_count_q <= rx_count_q + CntW'(1);
            else if (!rx_push && rx_pop) rx_count_q <= rx_count_q - CntW'(1);
        end
    end

    // Command FSM with registered one-cycle response strobe.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q               <= StIdle;
            wait_cnt_q            <= '0;
            dropped_q             <= 1'b0;
            from_peripheral       <= RespNone;
            from_peripheral_data  <= '0;
            from_peripheral_valid <= 1'b0;
        end else begin
            from_peripheral       <= RespNone;
            from_peripheral_data  <= '0;
            from_peripheral_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (to_peripheral_valid) begin
                        case (to_peripheral)
                            CmdWrite: begin
                                from_peripheral       <= tx_full ? RespErr : RespAck;
                                from_peripheral_valid <= 1'b1;
                            end
                            CmdRead: begin
                                if (!rx_empty) begin
                                    from_peripheral       <= RespData;
                                    from_peripheral_data  <= rx_head;
                                    from_peripheral_valid <= 1'b1;
                                end else begin
                                    state_q    <= StWait;
                                    wait_cnt_q <= TmoW'(TIMEOUT);
                                end
                            end
                            CmdStatus: begin
                                from_peripheral       <= RespData;
                                from_peripheral_data  <= status_word;
                                from_peripheral_valid <= 1'b1;
                                dropped_q             <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                StWait: begin
                    if (!rx_empty) begin
                        from_peripheral       <= RespData;
                        from_peripheral_data  <= rx_head;
                        from_peripheral_valid <= 1'b1;
                        state_q               <= StIdle;
                    end else if (wait_cnt_q == TmoW'(1)) begin
                        from_peripheral       <= RespErr;
                        from_peripheral_valid <= 1'b1;
                        state_q               <= StIdle;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - TmoW'(1);
                    end
                    // Commands cannot be served while blocked; remember the loss.
                    if (to_peripheral_valid && (to_peripheral != CmdNop)) dropped_q <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_peripheral_mailbox.sv
// Bench for peripheral_mailbox: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_peripheral_mailbox;

    localparam int DW = 32;
    localparam int DEPTH = 8;
    localparam int TMO = 16;

    localparam logic [1:0] NOP = 2'b00, WR = 2'b01, RD = 2'b10, ST = 2'b11;
    localparam logic [1:0] ACK = 2'b01, DAT = 2'b10, ERR = 2'b11;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [1:0]    to_peripheral = NOP;
    logic [DW-1:0] to_peripheral_data = '0;
    logic          to_peripheral_valid = 1'b0;
    logic [1:0]    from_peripheral;
    logic [DW-1:0] from_peripheral_data;
    logic          from_peripheral_valid;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic [DW-1:0] rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          rx_ready;

    int tests = 0;
    int fails = 0;

    peripheral_mailbox #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH),
        .TIMEOUT(TMO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .to_peripheral(to_peripheral),
        .to_peripheral_data(to_peripheral_data),
        .to_peripheral_valid(to_peripheral_valid),
        .from_peripheral(from_peripheral),
        .from_peripheral_data(from_peripheral_data),
        .from_peripheral_valid(from_peripheral_valid),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] tx_q[$];
    logic [DW-1:0] rx_q[$];
    bit            m_waiting = 0;
    int            m_remain = 0;
    bit            m_dropped = 0;
    bit            m_valid = 0;
    logic [1:0]    m_code = '0;
    logic [DW-1:0] m_data = '0;

    task automatic model_clear();
        tx_q.delete();
        rx_q.delete();
        m_waiting = 0;
        m_remain = 0;
        m_dropped = 0;
        m_valid = 0;
        m_code = '0;
        m_data = '0;
    endtask

    task automatic model_step();
        int txn = tx_q.size();
        int rxn = rx_q.size();
        logic [DW-1:0] w;
        m_valid = 0;
        m_code = '0;
        m_data = '0;
        if (txn != 0 && tx_ready) w = tx_q.pop_front();
        if (!m_waiting) begin
            if (to_peripheral_valid) begin
                case (to_peripheral)
                    WR: begin
                        m_valid = 1;
                        if (txn < DEPTH) begin
                            m_code = ACK;
                            tx_q.push_back(to_peripheral_data);
                        end else m_code = ERR;
                    end
                    RD: begin
                        if (rxn != 0) begin
                            m_valid = 1;
                            m_code = DAT;
                            m_data = rx_q.pop_front();
                        end else begin
                            m_waiting = 1;
                            m_remain = TMO;
                        end
                    end
                    ST: begin
                        m_valid = 1;
                        m_code = DAT;
                        m_data = (txn == DEPTH ? 1 : 0) | (txn == 0 ? 2 : 0) |
                                 (rxn == DEPTH ? 4 : 0) | (rxn == 0 ? 8 : 0) |
                                 (m_dropped ? 16 : 0) | (txn << 8) | (rxn << 16);
                        m_dropped = 0;
                    end
                    default: ;
                endcase
            end
        end else begin
            if (rxn != 0) begin
                m_valid = 1;
                m_code = DAT;
                m_data = rx_q.pop_front();
                m_waiting = 0;
            end else if (m_remain == 1) begin
                m_valid = 1;
                m_code = ERR;
                m_waiting = 0;
            end else m_remain--;
            if (to_peripheral_valid && to_peripheral != NOP) m_dropped = 1;
        end
        if (rx_valid && rxn < DEPTH) rx_q.push_back(rx_data);
    endtask

    always @(negedge reset) model_clear();

    // Advance the model on each edge, then compare settled DUT outputs.
    always @(posedge clock) begin
        if (!reset) model_clear();
        else model_step();
        #1;
        check("resp_valid", {31'b0, from_peripheral_valid}, {31'b0, m_valid});
        if (m_valid) begin
            check("resp_code", {30'b0, from_peripheral}, {30'b0, m_code});
            check("resp_data", from_peripheral_data, m_data);
        end
        check("tx_valid", {31'b0, tx_valid}, {31'b0, tx_q.size() != 0});
        check("tx_data", tx_data, tx_q.size() != 0 ? tx_q[0] : '0);
        check("rx_ready", {31'b0, rx_ready}, {31'b0, rx_q.size() < DEPTH});
    end

    // ---------------- directed stimulus ----------------
    task automatic send(input logic [1:0] cmd, input logic [DW-1:0] d);
        @(negedge clock);
        to_peripheral = cmd;
        to_peripheral_data = d;
        to_peripheral_valid = 1'b1;
        @(posedge clock);
        #2;
        to_peripheral_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clock);
        @(posedge clock);
        #2;
    endtask

    task automatic expect_resp(input string name, input logic [1:0] code, input logic [DW-1:0] d);
        check({name, ".valid"}, {31'b0, from_peripheral_valid}, 32'd1);
        check({name, ".code"}, {30'b0, from_peripheral}, {30'b0, code});
        check({name, ".data"}, from_peripheral_data, d);
    endtask

    task automatic drain_tx(input int n, input logic [DW-1:0] first);
        @(negedge clock);
        tx_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            check("drain.tx_data", tx_data, first + DW'(i));
            @(negedge clock);
        end
        tx_ready = 1'b0;
        check("drain.tx_valid", {31'b0, tx_valid}, 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clock);
        #2;
        check("rst.valid", {31'b0, from_peripheral_valid}, 32'd0);
        check("rst.code", {30'b0, from_peripheral}, 32'd0);
        check("rst.data", from_peripheral_data, 32'd0);
        check("rst.tx_valid", {31'b0, tx_valid}, 32'd0);
        check("rst.tx_data", tx_data, 32'd0);
        check("rst.rx_ready", {31'b0, rx_ready}, 32'd1);
        @(negedge clock);
        reset = 1'b1;

        // Writes and drain
        send(WR, 32'hA);
        expect_resp("wr_a", ACK, 32'h0);
        send(WR, 32'hB);
        expect_resp("wr_b", ACK, 32'h0);
        send(WR, 32'hC);
        expect_resp("wr_c", ACK, 32'h0);
        check("wr.tx_valid", {31'b0, tx_valid}, 32'd1);
        check("wr.tx_head", tx_data, 32'hA);
        drain_tx(3, 32'hA);

        // TX full
        for (int i = 1; i <= 8; i++) begin
            send(WR, DW'(i));
            expect_resp("fill", ACK, 32'h0);
        end
        send(WR, 32'd9);
        expect_resp("wr_full", ERR, 32'h0);
        send(ST, 32'h0);
        // tx_count 8, tx_full, and rx_empty (bit 3) since RX holds nothing
        expect_resp("st_full", DAT, 32'h0000_0809);
        drain_tx(8, 32'd1);

        // Blocking read satisfied by a host push five edges later
        send(RD, 32'h0);
        check("blk.no_resp0", {31'b0, from_peripheral_valid}, 32'd0);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clock);
            rx_valid = (i == 5);
            rx_data = 32'hDEAD_BEEF;
            @(posedge clock);
            #2;
            check("blk.no_resp", {31'b0, from_peripheral_valid}, 32'd0);
        end
        @(negedge clock);
        rx_valid = 1'b0;
        @(posedge clock);
        #2;
        expect_resp("blk.data", DAT, 32'hDEAD_BEEF);
        send(ST, 32'h0);
        expect_resp("blk.idle_status", DAT, 32'h0000_000A);

        // Blocking read timeout with a WRITE dropped during the wait
        send(RD, 32'h0);
        check("tmo.no_resp0", {31'b0, from_peripheral_valid}, 32'd0);
        for (int i = 1; i <= TMO; i++) begin
            if (i == 3) send(WR, 32'h55);
            else idle_cycle();
            if (i < TMO) check("tmo.no_resp", {31'b0, from_peripheral_valid}, 32'd0);
            else expect_resp("tmo.err", ERR, 32'h0);
        end
        check("tmo.tx_untouched", {31'b0, tx_valid}, 32'd0);
        send(ST, 32'h0);
        expect_resp("tmo.st_dropped", DAT, 32'h0000_001A);
        send(ST, 32'h0);
        expect_resp("tmo.st_cleared", DAT, 32'h0000_000A);

        // Wrap and concurrency: one word in flight, host push + core READ each cycle
        @(negedge clock);
        rx_valid = 1'b1;
        rx_data = 32'h100;
        @(posedge clock);
        #2;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            rx_data = 32'h101 + DW'(i);
            to_peripheral = RD;
            to_peripheral_valid = 1'b1;
            @(posedge clock);
            #2;
            expect_resp("wrap.read", DAT, 32'h100 + DW'(i));
        end
        @(negedge clock);
        rx_valid = 1'b0;
        to_peripheral_valid = 1'b0;
        send(ST, 32'h0);
        expect_resp("wrap.status", DAT, 32'h0001_0002);
        send(RD, 32'h0);
        expect_resp("wrap.last", DAT, 32'h114);

        // Reset during WAIT
        send(WR, 32'h77);
        expect_resp("rw.wr", ACK, 32'h0);
        send(RD, 32'h0);
        repeat (3) @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check("arst.valid", {31'b0, from_peripheral_valid}, 32'd0);
        check("arst.code", {30'b0, from_peripheral}, 32'd0);
        check("arst.data", from_peripheral_data, 32'd0);
        check("arst.tx_valid", {31'b0, tx_valid}, 32'd0);
        check("arst.tx_data", tx_data, 32'd0);
        check("arst.rx_ready", {31'b0, rx_ready}, 32'd1);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < TMO + 4; i++) begin
            idle_cycle();
            check("arst.no_resp", {31'b0, from_peripheral_valid}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
